// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and constants for the CPU memory arbiter
package cpu_mem_pkg;

   localparam int BLK_WORDS = 8;
   localparam int BLK_IDX_W = $clog2(BLK_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_WRITE = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache fill and write-through arbiter for the pipelined main memory
module mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int BLOCK_WORDS = BLK_WORDS,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_req,
   input  logic [ADDR_W-1:0]              i_addr,
   output logic                           i_grant,
   output logic                           i_rvalid,
   output logic                           i_done,
   input  logic                           d_req,
   input  logic                           d_wr,
   input  logic [ADDR_W-1:0]              d_addr,
   input  logic [DATA_W-1:0]              d_wdata,
   output logic                           d_grant,
   output logic                           d_rvalid,
   output logic                           d_done,
   output logic [$clog2(BLOCK_WORDS)-1:0] rword,
   output logic [DATA_W-1:0]              rdata,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata,
   input  logic                           mem_rvalid
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);

   arb_state_e        state_q;
   owner_e            owner_q;
   owner_e            last_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [CNT_W-1:0]  issue_cnt_q;
   logic [IDX_W-1:0]  recv_cnt_q;
   logic              i_grant_q;
   logic              d_grant_q;
   logic              mem_en_q;
   logic              mem_wr_q;
   logic              wr_done_q;

   logic              ret_valid;
   logic              ret_last;
   logic              pick_i;
   logic [ADDR_W-1:0] i_base;
   logic [ADDR_W-1:0] d_base;
   logic [ADDR_W-1:0] issue_addr_d;

   always_comb begin
      ret_valid    = mem_rvalid && (state_q == ST_FILL || state_q == ST_DRAIN);
      ret_last     = ret_valid && (recv_cnt_q == IDX_W'(BLOCK_WORDS - 1));
      // Round-robin: I wins a tie only when D owned the memory last.
      pick_i       = i_req && (!d_req || last_q == OWN_D);
      i_base       = i_addr & ALIGN_MASK;
      d_base       = d_addr & ALIGN_MASK;
      issue_addr_d = base_q + ADDR_W'({issue_cnt_q, 1'b0});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_I;
         last_q      <= OWN_D;
         base_q      <= '0;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         i_grant_q   <= 1'b0;
         d_grant_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wr_done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_i) begin
                  owner_q     <= OWN_I;
                  last_q      <= OWN_I;
                  i_grant_q   <= 1'b1;
                  state_q     <= ST_FILL;
                  base_q      <= i_base;
                  mem_en_q    <= 1'b1;
                  mem_addr_q  <= i_base;
                  issue_cnt_q <= CNT_W'(1);
                  recv_cnt_q  <= '0;
               end else if (d_req) begin
                  owner_q   <= OWN_D;
                  last_q    <= OWN_D;
                  d_grant_q <= 1'b1;
                  mem_en_q  <= 1'b1;
                  if (d_wr) begin
                     state_q     <= ST_WRITE;
                     mem_wr_q    <= 1'b1;
                     mem_addr_q  <= d_addr;
                     mem_wdata_q <= d_wdata;
                     wr_done_q   <= 1'b1;
                  end else begin
                     state_q     <= ST_FILL;
                     base_q      <= d_base;
                     mem_addr_q  <= d_base;
                     issue_cnt_q <= CNT_W'(1);
                     recv_cnt_q  <= '0;
                  end
               end
            end
            ST_FILL: begin
               if (issue_cnt_q == CNT_W'(BLOCK_WORDS)) begin
                  state_q    <= ST_DRAIN;
                  mem_en_q   <= 1'b0;
                  mem_addr_q <= '0;
               end else begin
                  mem_addr_q  <= issue_addr_d;
                  issue_cnt_q <= issue_cnt_q + 1'b1;
               end
               if (ret_valid) begin
                  recv_cnt_q <= recv_cnt_q + 1'b1;
               end
               // Last word can land while still issuing; skip DRAIN entirely then.
               if (ret_last) begin
                  state_q     <= ST_IDLE;
                  i_grant_q   <= 1'b0;
                  d_grant_q   <= 1'b0;
                  mem_en_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  issue_cnt_q <= '0;
                  recv_cnt_q  <= '0;
               end
            end
            ST_DRAIN: begin
               if (ret_valid) begin
                  recv_cnt_q <= recv_cnt_q + 1'b1;
               end
               if (ret_last) begin
                  state_q     <= ST_IDLE;
                  i_grant_q   <= 1'b0;
                  d_grant_q   <= 1'b0;
                  issue_cnt_q <= '0;
                  recv_cnt_q  <= '0;
               end
            end
            ST_WRITE: begin
               state_q     <= ST_IDLE;
               d_grant_q   <= 1'b0;
               mem_en_q    <= 1'b0;
               mem_wr_q    <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
               wr_done_q   <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_grant   = i_grant_q;
   assign d_grant   = d_grant_q;
   assign i_rvalid  = ret_valid && (owner_q == OWN_I);
   assign d_rvalid  = ret_valid && (owner_q == OWN_D);
   assign i_done    = ret_last && (owner_q == OWN_I);
   assign d_done    = (ret_last && (owner_q == OWN_D)) || wr_done_q;
   assign rword     = ret_valid ? recv_cnt_q : '0;
   assign rdata     = ret_valid ? mem_rdata : '0;
   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed, table-driven bench for mem_arbiter
module tb_mem_arbiter;

   typedef struct packed {
      logic        ig;
      logic        irv;
      logic        idn;
      logic        dg;
      logic        drv;
      logic        ddn;
      logic        en;
      logic        wr;
      logic [2:0]  rw;
      logic [15:0] addr;
      logic [15:0] rd;
      logic [15:0] wd;
   } row_t;

   typedef struct {
      logic i_req;
      row_t exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_grant, i_rvalid, i_done;
   logic        d_grant, d_rvalid, d_done;
   logic [2:0]  rword;
   logic [15:0] rdata;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rvalid;

   logic        v1 = 1'b0, v2 = 1'b0;
   logic [15:0] a1 = '0, a2 = '0;
   logic        force_rv;
   logic [15:0] force_data;
   logic [15:0] wr_addr_log = '0, wr_data_log = '0;

   int total;
   int bad;
   vec_t vec[12];

   always #5 clk = ~clk;

   mem_arbiter #(.BLOCK_WORDS(8), .ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_rvalid(i_rvalid), .i_done(i_done),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_grant(d_grant), .d_rvalid(d_rvalid), .d_done(d_done),
      .rword(rword), .rdata(rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   // Two-cycle pipelined memory; word contents are addr ^ 16'h5A5A.
   always @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= mem_en && !mem_wr;
         v2 <= v1;
      end
      a1 <= mem_addr;
      a2 <= a1;
      if (!rst && mem_en && mem_wr) begin
         wr_addr_log <= mem_addr;
         wr_data_log <= mem_wdata;
      end
   end

   assign mem_rvalid = v2 | force_rv;
   assign mem_rdata  = v2 ? (a2 ^ 16'h5A5A) : (force_rv ? force_data : 16'h0000);

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic row_t mk(input logic ig, irv, idn, dg, drv, ddn, en, wr,
                               input logic [2:0] rw, input logic [15:0] a, rd, wd);
      row_t r;
      r.ig = ig; r.irv = irv; r.idn = idn; r.dg = dg; r.drv = drv; r.ddn = ddn;
      r.en = en; r.wr = wr; r.rw = rw; r.addr = a; r.rd = rd; r.wd = wd;
      return r;
   endfunction

   function automatic row_t obs();
      return mk(i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done,
                mem_en, mem_wr, rword, mem_addr, rdata, mem_wdata);
   endfunction

   // Runs a granted fill to completion, checking issue addresses, returned words and isolation.
   task automatic fill_run(input bit side, input logic [15:0] base, input string nm, input int raise_at);
      int n_iss, n_ret;
      bit fin;
      logic [15:0] ea;
      n_iss = 0; n_ret = 0; fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
         if (c == raise_at) begin
            d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4006;
         end
         if (mem_en) begin
            ea = base + 16'(2 * n_iss);
            chk({nm, "_addr"}, 64'(mem_addr), 64'(ea));
            n_iss++;
         end
         if (side ? d_rvalid : i_rvalid) begin
            ea = (base + 16'(2 * n_ret)) ^ 16'h5A5A;
            chk({nm, "_ret"}, 64'({rword, rdata}), 64'({3'(n_ret), ea}));
            n_ret++;
         end
         chk({nm, "_iso"},
             64'(side ? {i_grant, i_rvalid, i_done, d_grant} : {d_grant, d_rvalid, d_done, i_grant}),
             64'(4'b0001));
         if (side ? d_done : i_done) begin
            chk({nm, "_count"}, 64'({n_iss[7:0], n_ret[7:0]}), 64'(16'h0808));
            if (side) d_req = 1'b0;
            else i_req = 1'b0;
            fin = 1'b1;
         end
         step();
      end
      if (!fin) chk({nm, "_timeout"}, 64'(fin), 64'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      row_t wexp;
      total = 0; bad = 0;
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      force_rv = 1'b0; force_data = '0;

      vec[0]  = '{1'b1, mk(0,0,0,0,0,0,0,0,3'd0,16'h0000,16'h0000,16'h0000)};
      vec[1]  = '{1'b1, mk(1,0,0,0,0,0,1,0,3'd0,16'h0030,16'h0000,16'h0000)};
      vec[2]  = '{1'b1, mk(1,0,0,0,0,0,1,0,3'd0,16'h0032,16'h0000,16'h0000)};
      vec[3]  = '{1'b1, mk(1,1,0,0,0,0,1,0,3'd0,16'h0034,16'h5A6A,16'h0000)};
      vec[4]  = '{1'b1, mk(1,1,0,0,0,0,1,0,3'd1,16'h0036,16'h5A68,16'h0000)};
      vec[5]  = '{1'b1, mk(1,1,0,0,0,0,1,0,3'd2,16'h0038,16'h5A6E,16'h0000)};
      vec[6]  = '{1'b1, mk(1,1,0,0,0,0,1,0,3'd3,16'h003A,16'h5A6C,16'h0000)};
      vec[7]  = '{1'b1, mk(1,1,0,0,0,0,1,0,3'd4,16'h003C,16'h5A62,16'h0000)};
      vec[8]  = '{1'b1, mk(1,1,0,0,0,0,1,0,3'd5,16'h003E,16'h5A60,16'h0000)};
      vec[9]  = '{1'b1, mk(1,1,0,0,0,0,0,0,3'd6,16'h0000,16'h5A66,16'h0000)};
      vec[10] = '{1'b0, mk(1,1,1,0,0,0,0,0,3'd7,16'h0000,16'h5A64,16'h0000)};
      vec[11] = '{1'b0, mk(0,0,0,0,0,0,0,0,3'd0,16'h0000,16'h0000,16'h0000)};

      step(); step();
      chk("reset_outputs", 64'(obs()), 64'(0));
      rst = 1'b0;

      // Single I fill from an unaligned address, cycle by cycle.
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("fill_row%0d", k), 64'(obs()), 64'(vec[k].exp));
         i_req = vec[k].i_req;
         i_addr = 16'h0036;
         step();
      end

      // D write-through, with a stray return during the write cycle.
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1002; d_wdata = 16'hBEEF;
      step();
      wexp = mk(0,0,0,1,0,1,1,1,3'd0,16'h1002,16'h0000,16'hBEEF);
      chk("wr_cycle", 64'(obs()), 64'(wexp));
      force_rv = 1'b1; force_data = 16'h7777;
      #1;
      chk("wr_ignore_ret", 64'(obs()), 64'(wexp));
      force_rv = 1'b0;
      d_req = 1'b0;
      step();
      chk("wr_after", 64'(obs()), 64'(0));
      chk("wr_mem_log", 64'({wr_addr_log, wr_data_log}), 64'({16'h1002, 16'hBEEF}));

      // Returns in IDLE are ignored and leave the receive counter alone.
      force_rv = 1'b1; force_data = 16'h1234;
      #1;
      chk("ign_idle", 64'(obs()), 64'(0));
      step();
      force_rv = 1'b0;
      chk("ign_idle2", 64'(obs()), 64'(0));
      i_req = 1'b1; i_addr = 16'h0508;
      step();
      chk("ign_grant", 64'({i_grant, d_grant}), 64'(2'b10));
      fill_run(1'b0, 16'h0500, "ign_fill", -1);

      // Tie after reset: I first, then D; second tie goes to I again.
      rst = 1'b1;
      step();
      rst = 1'b0;
      i_req = 1'b1; i_addr = 16'h0100;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2008;
      step();
      chk("tie1_grant", 64'({i_grant, d_grant}), 64'(2'b10));
      fill_run(1'b0, 16'h0100, "tie1_i", -1);
      chk("tie1_turn", 64'({i_grant, d_grant}), 64'(2'b00));
      step();
      chk("tie1_dgrant", 64'({i_grant, d_grant, mem_addr}), 64'({2'b01, 16'h2000}));
      fill_run(1'b1, 16'h2000, "tie1_d", -1);
      i_req = 1'b1; i_addr = 16'h0110;
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h3005; d_wdata = 16'h1357;
      step();
      chk("tie2_grant", 64'({i_grant, d_grant}), 64'(2'b10));
      fill_run(1'b0, 16'h0110, "tie2_i", -1);
      chk("tie2_turn", 64'({i_grant, d_grant}), 64'(2'b00));
      step();
      chk("tie2_write", 64'(obs()), 64'(mk(0,0,0,1,0,1,1,1,3'd0,16'h3005,16'h0000,16'h1357)));
      d_req = 1'b0;
      step();

      // D request arriving at cycle 3 of an I fill waits for i_done.
      i_req = 1'b1; i_addr = 16'h040C;
      step();
      chk("mid_igrant", 64'({i_grant, d_grant}), 64'(2'b10));
      fill_run(1'b0, 16'h0400, "mid_i", 2);
      chk("mid_turn", 64'({i_grant, d_grant}), 64'(2'b00));
      step();
      chk("mid_dgrant", 64'({d_grant, mem_addr}), 64'({1'b1, 16'h4000}));
      fill_run(1'b1, 16'h4000, "mid_d", -1);

      // Reset after four issues, then a clean fill from word 0.
      i_req = 1'b1; i_addr = 16'h0200;
      step(); step(); step(); step();
      chk("rst_pre", 64'(mem_addr), 64'(16'h0206));
      rst = 1'b1; i_req = 1'b0;
      step();
      chk("rst_mid", 64'(obs()), 64'(0));
      rst = 1'b0;
      i_req = 1'b1; i_addr = 16'h0302;
      step();
      chk("rst_regrant", 64'({i_grant, mem_addr}), 64'({1'b1, 16'h0300}));
      fill_run(1'b0, 16'h0300, "rst_refill", -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
